dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Two-requester arbiter/sequencer in front of the 64-bit byte-addressed data memory.
//  Port 0 is the core load/store unit; port 1 is the DMA/array-init engine.
//  Grants one access at a time with round-robin priority and drives the memory's
//  memoryread/memorywrite strobes. Range/alignment-checks each access and returns
//  registered read data plus ack/err to the winner.
// PARAMETERS
//  DATA_W     64  data width; one access = one 8-byte doubleword
//  ADDR_W     64  address width
//  MEM_BYTES  64  memory size in bytes; legal addresses 0..MEM_BYTES-8
// PORTS
//  clk            in   1       single clock; all state updates on posedge
//  reset          in   1       synchronous, active-high
//  req0/req1      in   1       access request, held until the matching ack
//  we0/we1        in   1       1 = write, 0 = read; stable while req high
//  addr0/addr1    in   ADDR_W  byte address; stable while req high
//  wdata0/wdata1  in   DATA_W  write data; stable while req high
//  ack0/ack1      out  1       one-cycle completion pulse
//  err0/err1      out  1       valid with ack: access rejected, no memory effect
//  rdata0/rdata1  out  DATA_W  read result, valid with ack; held until next ack to that port
//  busy           out  1       high in ACCESS
//  mem_address    out  ADDR_W  to memory address
//  mem_write_data out  DATA_W  to memory write_data
//  mem_memoryread out  1       to memory memoryread
//  mem_memorywrite out 1       to memory memorywrite
//  mem_read_data  in   DATA_W  combinational read data from memory
// BEHAVIOUR
//  Reset: state=IDLE, last_grant=1 (port 0 wins first tie); ack*, err*, busy,
//   mem_* strobes = 0; rdata* = 0; mem_address and mem_write_data = 0.
//  FSM IDLE: eligible_i = req_i & ~ack_i, so a port acked this cycle is masked.
//   One eligible port: grant it. Both eligible: grant the port != last_grant.
//   On grant (posedge): latch owner, we, addr, wdata; last_grant <= owner;
//   err_l <= (addr[2:0] != 0) | (addr > MEM_BYTES-8); go to ACCESS. No eligible port: stay.
//  FSM ACCESS (exactly 1 cycle): mem_address = latched addr.
//   mem_write_data = latched wdata.
//   mem_memoryread = ~we_l & ~err_l.
//   mem_memorywrite = we_l & ~err_l & ~reset.
//   Posedge: ack_owner <= 1; err_owner <= err_l.
//   If read & ~err_l: rdata_owner <= mem_read_data.
//   If err_l: rdata_owner <= 0. A write leaves rdata unchanged.
//   Go to IDLE.
//  Strobes are 0 in IDLE; mem_address and mem_write_data are 0 in IDLE.
//  ack/err are registered one-cycle pulses. The non-owner's ack/err stay 0.
//  Latency: req high at edge k -> ACCESS in cycle k..k+1 -> ack high in cycle k+1..k+2.
//   The write commits at edge k+1. Peak throughput is 1 access per 2 cycles.
//  Requester drops or changes its request at the edge ending its ack cycle. The other
//   port may be granted during that ack cycle, giving back-to-back ACCESS every 2 cycles.
//  Errors: no strobe asserted and memory is untouched; the ack still occurs.
//  Reset during ACCESS: the write is suppressed at that edge, no ack issues, and the
//   block returns to IDLE with reset values.
//  Requests that drop before ack are a protocol violation: behaviour undefined.
// TESTING
//  1 Reset, req0 read addr=8 (mem=2) -> ACCESS next cycle, mem_memoryread=1,
//    ack0 at 2nd cycle, rdata0=2, err0=0.
//  2 req0 write addr=16 wdata=0xAB, then read 16 -> mem_memorywrite for 1 cycle;
//    read returns 0xAB; ack1 never asserts.
//  3 req0 & req1 held continuously after reset -> grant order 0,1,0,1;
//    an ack is issued every 2 cycles; no port is starved.
//  4 req1 read addr=12 (misaligned) and addr=64 (out of range) -> no strobes,
//    ack1=1, err1=1, rdata1=0.
//  5 reset asserted during a write ACCESS to addr=0 -> mem_memorywrite=0 at that edge,
//    mem[0] unchanged, no ack, IDLE.
//  6 req0 re-asserts with new addr in the cycle after ack0 while req1 is idle ->
//    port 0 is regranted in that cycle with no lost or duplicate access.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Two-port round-robin arbiter in front of the 64-bit data memory. Port 0 is the
// load/store unit and port 1 is the DMA/array-init engine. Each access is one
// 8-byte doubleword. Every grant spends exactly one cycle in ACCESS. The owner
// then gets a registered one-cycle ack, with err and read data alongside it.
// Misaligned or out-of-range accesses are acked with err and never touch memory.
module dmem_port_arbiter #(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 64,
    parameter int MEM_BYTES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_memoryread,
    output logic              mem_memorywrite,
    input  logic [DATA_W-1:0] mem_read_data
);

    // Highest legal doubleword start address.
    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 8);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    // An access is rejected when it is not doubleword aligned or runs past the end of memory.
    function automatic logic access_err(input logic [ADDR_W-1:0] a);
        return (a[2:0] != 3'd0) || (a > MAX_ADDR);
    endfunction

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                owner_q, owner_d;
    logic                we_q, we_d;
    logic                err_l_q, err_l_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;
    logic                err0_q, err0_d;
    logic                err1_q, err1_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;

    logic [1:0]          eligible_s;
    logic                grant_valid_s;
    logic                grant_port_s;
    logic                sel_we_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_wdata_s;
    logic [DATA_W-1:0]   rdata_new_s;

    // Round-robin pick; a port whose ack is showing this cycle is masked so it is not re-served.
    always_comb begin
        eligible_s    = {req1 & ~ack1_q, req0 & ~ack0_q};
        grant_valid_s = 1'b0;
        grant_port_s  = 1'b0;
        case (eligible_s)
            2'b01: begin
                grant_valid_s = 1'b1;
                grant_port_s  = 1'b0;
            end
            2'b10: begin
                grant_valid_s = 1'b1;
                grant_port_s  = 1'b1;
            end
            2'b11: begin
                grant_valid_s = 1'b1;
                grant_port_s  = ~last_grant_q;
            end
            default: begin
                grant_valid_s = 1'b0;
                grant_port_s  = 1'b0;
            end
        endcase
    end

    // Steer the winning port's request fields toward the latches.
    always_comb begin
        if (grant_port_s) begin
            sel_we_s    = we1;
            sel_addr_s  = addr1;
            sel_wdata_s = wdata1;
        end else begin
            sel_we_s    = we0;
            sel_addr_s  = addr0;
            sel_wdata_s = wdata0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: IDLE waits for a grant; ACCESS always lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid_s) begin
                    state_d = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: the memory interface is driven only in ACCESS and is quiet in IDLE.
    always_comb begin
        busy            = 1'b0;
        mem_address     = '0;
        mem_write_data  = '0;
        mem_memoryread  = 1'b0;
        mem_memorywrite = 1'b0;
        case (state_q)
            ST_ACCESS: begin
                busy            = 1'b1;
                mem_address     = addr_q;
                mem_write_data  = wdata_q;
                mem_memoryread  = ~we_q & ~err_l_q;
                // A reset arriving during ACCESS must not let the write commit.
                mem_memorywrite = we_q & ~err_l_q & ~reset;
            end
            default: begin
                busy            = 1'b0;
                mem_address     = '0;
                mem_write_data  = '0;
                mem_memoryread  = 1'b0;
                mem_memorywrite = 1'b0;
            end
        endcase
    end

    // Read data returned for this access: zero on error, memory on read, held on write.
    always_comb begin
        if (err_l_q) begin
            rdata_new_s = '0;
        end else if (!we_q) begin
            rdata_new_s = mem_read_data;
        end else if (owner_q) begin
            rdata_new_s = rdata1_q;
        end else begin
            rdata_new_s = rdata0_q;
        end
    end

    // Next values for the latched request and the completion outputs.
    always_comb begin
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        we_d         = we_q;
        err_l_d      = err_l_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        err0_d       = 1'b0;
        err1_d       = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid_s) begin
                    last_grant_d = grant_port_s;
                    owner_d      = grant_port_s;
                    we_d         = sel_we_s;
                    addr_d       = sel_addr_s;
                    wdata_d      = sel_wdata_s;
                    err_l_d      = access_err(sel_addr_s);
                end else begin
                    last_grant_d = last_grant_q;
                end
            end
            ST_ACCESS: begin
                if (owner_q) begin
                    ack1_d   = 1'b1;
                    err1_d   = err_l_q;
                    rdata1_d = rdata_new_s;
                end else begin
                    ack0_d   = 1'b1;
                    err0_d   = err_l_q;
                    rdata0_d = rdata_new_s;
                end
            end
            default: begin
                ack0_d = 1'b0;
                ack1_d = 1'b0;
            end
        endcase
    end

    // Latched request, round-robin pointer and registered port outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            err_l_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            err_l_q      <= err_l_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign ack0   = ack0_q;
    assign ack1   = ack1_q;
    assign err0   = err0_q;
    assign err1   = err1_q;
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Testbench for dmem_port_arbiter: an 8-doubleword memory sits behind the DUT, and a
// transaction-level reference model predicts err, rdata and memory contents.
module tb_dmem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        mem_init;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [63:0] addr [2];
    logic [63:0] wdata [2];
    logic        ack0, ack1, err0, err1, busy;
    logic [63:0] rdata0, rdata1;
    logic [63:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_memoryread, mem_memorywrite;

    logic [63:0] tb_mem [8];
    logic [63:0] model_mem [8];
    logic [63:0] model_rdata [2];

    int checks;
    int failures;

    typedef struct {
        int          lat;
        logic        e;
        logic [63:0] rd;
        int          rd_c;
        int          wr_c;
        int          oth;
        int          busy_c;
        logic [63:0] addr_seen;
        logic [63:0] wd_seen;
    } obs_t;

    dmem_port_arbiter #(.DATA_W(64), .ADDR_W(64), .MEM_BYTES(64)) dut (
        .clk(clk), .reset(reset),
        .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
        .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_memoryread(mem_memoryread), .mem_memorywrite(mem_memorywrite),
        .mem_read_data(mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory behind the arbiter: combinational read, write on posedge.
    assign mem_read_data = tb_mem[mem_address[5:3]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 8; i++) tb_mem[i] <= 64'(2 * i);
        end else if (mem_memorywrite) begin
            tb_mem[mem_address[5:3]] <= mem_write_data;
        end
    end

    // Reference model of one completed access.
    task automatic model_access(input int p, input logic w, input logic [63:0] a,
                                input logic [63:0] d, output logic e, output logic [63:0] rd);
        e = ((a % 64'd8) != 64'd0) || (a > 64'd56);
        if (e) model_rdata[p] = 64'd0;
        else if (w) model_mem[int'(a / 64'd8)] = d;
        else model_rdata[p] = model_mem[int'(a / 64'd8)];
        rd = model_rdata[p];
    endtask

    function automatic logic [63:0] get_rdata(input int p);
        return (p == 0) ? rdata0 : rdata1;
    endfunction

    // Drives one request on port p, waits a bounded time for its ack, and records what it saw.
    task automatic run_single(input int p, input logic w, input logic [63:0] a,
                              input logic [63:0] d, output obs_t o);
        o.lat = -1; o.e = 1'b0; o.rd = 64'd0; o.rd_c = 0; o.wr_c = 0; o.oth = 0;
        o.busy_c = 0; o.addr_seen = 64'd0; o.wd_seen = 64'd0;
        req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
        for (int c = 1; c <= 8 && o.lat < 0; c++) begin
            @(posedge clk); #1;
            if (mem_memoryread) o.rd_c++;
            if (mem_memorywrite) o.wr_c++;
            if (busy) begin o.busy_c++; o.addr_seen = mem_address; o.wd_seen = mem_write_data; end
            if ((p == 0) ? ack1 : ack0) o.oth++;
            if ((p == 0) ? ack0 : ack1) begin
                o.lat = c;
                o.e = (p == 0) ? err0 : err1;
                o.rd = get_rdata(p);
            end
        end
        @(posedge clk); #1;
        if (busy) o.busy_c++;
        if (ack0 || ack1) o.oth++;
        req[p] = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if ({ack0, ack1, err0, err1} !== 4'b0000) begin failures++;
            $display("FAIL reset_ack_err got=%b exp=0000", {ack0, ack1, err0, err1}); end
        checks++; if ({busy, mem_memoryread, mem_memorywrite} !== 3'b000) begin failures++;
            $display("FAIL reset_busy_strobes got=%b exp=000", {busy, mem_memoryread, mem_memorywrite}); end
        checks++; if ({rdata0, rdata1} !== 128'd0) begin failures++;
            $display("FAIL reset_rdata got=%h_%h exp=0", rdata0, rdata1); end
        checks++; if ({mem_address, mem_write_data} !== 128'd0) begin failures++;
            $display("FAIL reset_mem_bus got=%h_%h exp=0", mem_address, mem_write_data); end
    endtask

    task automatic test_read_basic();
        obs_t o; logic e; logic [63:0] rd;
        run_single(0, 1'b0, 64'd8, 64'd0, o);
        model_access(0, 1'b0, 64'd8, 64'd0, e, rd);
        checks++; if (o.lat !== 2) begin failures++; $display("FAIL read_latency got=%0d exp=2", o.lat); end
        checks++; if ({o.rd_c, o.wr_c} !== {32'd1, 32'd0}) begin failures++;
            $display("FAIL read_strobes got rd=%0d wr=%0d exp rd=1 wr=0", o.rd_c, o.wr_c); end
        checks++; if (o.addr_seen !== 64'd8) begin failures++; $display("FAIL read_addr got=%h exp=8", o.addr_seen); end
        checks++; if ({o.e, o.rd} !== {e, rd}) begin failures++;
            $display("FAIL read_data got err=%b rd=%h exp err=%b rd=%h", o.e, o.rd, e, rd); end
        checks++; if ({o.oth, o.busy_c} !== {32'd0, 32'd1}) begin failures++;
            $display("FAIL read_single got other=%0d busy=%0d exp 0 1", o.oth, o.busy_c); end
    endtask

    task automatic test_write_read();
        obs_t o; logic e; logic [63:0] rd;
        run_single(0, 1'b1, 64'd16, 64'hAB, o);
        model_access(0, 1'b1, 64'd16, 64'hAB, e, rd);
        checks++; if ({o.rd_c, o.wr_c, o.busy_c} !== {32'd0, 32'd1, 32'd1}) begin failures++;
            $display("FAIL write_strobes got rd=%0d wr=%0d busy=%0d exp 0 1 1", o.rd_c, o.wr_c, o.busy_c); end
        checks++; if (o.wd_seen !== 64'hAB) begin failures++; $display("FAIL write_data_bus got=%h exp=ab", o.wd_seen); end
        checks++; if ({o.lat, o.e, o.rd} !== {32'd2, e, rd}) begin failures++;
            $display("FAIL write_ack got lat=%0d err=%b rd=%h exp 2 %b %h", o.lat, o.e, o.rd, e, rd); end
        checks++; if (o.oth !== 0) begin failures++; $display("FAIL write_ack1 got=%0d exp=0", o.oth); end
        run_single(0, 1'b0, 64'd16, 64'd0, o);
        model_access(0, 1'b0, 64'd16, 64'd0, e, rd);
        checks++; if ({o.lat, o.e, o.rd} !== {32'd2, e, rd}) begin failures++;
            $display("FAIL readback got lat=%0d err=%b rd=%h exp 2 %b %h", o.lat, o.e, o.rd, e, rd); end
        checks++; if (o.oth !== 0) begin failures++; $display("FAIL readback_ack1 got=%0d exp=0", o.oth); end
    endtask

    task automatic test_errors();
        obs_t o; logic e; logic [63:0] rd;
        logic [63:0] bad [3];
        bad[0] = 64'd8; bad[1] = 64'd12; bad[2] = 64'd64;
        for (int i = 0; i < 3; i++) begin
            run_single(1, 1'b0, bad[i], 64'd0, o);
            model_access(1, 1'b0, bad[i], 64'd0, e, rd);
            checks++; if ({o.lat, o.e, o.rd} !== {32'd2, e, rd}) begin failures++;
                $display("FAIL err_ack[%0d] got lat=%0d err=%b rd=%h exp 2 %b %h", i, o.lat, o.e, o.rd, e, rd); end
            checks++; if ((o.rd_c + o.wr_c) !== (e ? 0 : 1)) begin failures++;
                $display("FAIL err_strobes[%0d] got=%0d exp=%0d", i, o.rd_c + o.wr_c, e ? 0 : 1); end
        end
    endtask

    task automatic test_regrant();
        obs_t o; logic e; logic [63:0] rd; logic [63:0] d;
        run_single(0, 1'b0, 64'd24, 64'd0, o);
        model_access(0, 1'b0, 64'd24, 64'd0, e, rd);
        checks++; if ({o.lat, o.busy_c, o.rd} !== {32'd2, 32'd1, rd}) begin failures++;
            $display("FAIL regrant_first got lat=%0d busy=%0d rd=%h exp 2 1 %h", o.lat, o.busy_c, o.rd, rd); end
        d = {$urandom, $urandom};
        run_single(0, 1'b1, 64'd40, d, o);
        model_access(0, 1'b1, 64'd40, d, e, rd);
        checks++; if ({o.lat, o.busy_c, o.wr_c, o.oth} !== {32'd2, 32'd1, 32'd1, 32'd0}) begin failures++;
            $display("FAIL regrant_second got lat=%0d busy=%0d wr=%0d oth=%0d exp 2 1 1 0", o.lat, o.busy_c, o.wr_c, o.oth); end
        checks++; if (tb_mem[5] !== model_mem[5]) begin failures++;
            $display("FAIL regrant_mem got=%h exp=%h", tb_mem[5], model_mem[5]); end
    endtask

    task automatic test_reset_during_write();
        logic [63:0] d;
        d = {$urandom, $urandom};
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 64'd0; wdata[0] = d;
        @(posedge clk); #1;
        checks++; if ({busy, mem_memorywrite} !== 2'b11) begin failures++;
            $display("FAIL rst_access got busy=%b wr=%b exp 1 1", busy, mem_memorywrite); end
        reset = 1'b1; #1;
        checks++; if (mem_memorywrite !== 1'b0) begin failures++;
            $display("FAIL rst_write_suppressed got=%b exp=0", mem_memorywrite); end
        req[0] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_rdata[0] = 64'd0; model_rdata[1] = 64'd0;
        checks++; if ({ack0, ack1, busy} !== 3'b000) begin failures++;
            $display("FAIL rst_no_ack got=%b exp=000", {ack0, ack1, busy}); end
        checks++; if (tb_mem[0] !== model_mem[0]) begin failures++;
            $display("FAIL rst_mem0 got=%h exp=%h", tb_mem[0], model_mem[0]); end
        checks++; if ({rdata0, rdata1} !== {model_rdata[0], model_rdata[1]}) begin failures++;
            $display("FAIL rst_rdata got=%h_%h exp=0", rdata0, rdata1); end
    endtask

    task automatic test_round_robin();
        int ports[$]; int cycs[$]; logic e; logic [63:0] rd; logic [63:0] a [2];
        a[0] = 64'(8 * $urandom_range(0, 7)); a[1] = 64'(8 * $urandom_range(0, 7));
        req = 2'b11; we = 2'b00; addr[0] = a[0]; addr[1] = a[1];
        for (int c = 1; c <= 20 && ports.size() < 4; c++) begin
            @(posedge clk); #1;
            if (ack0 && ack1) begin ports.push_back(2); cycs.push_back(c); end
            else if (ack0 || ack1) begin
                ports.push_back(ack1 ? 1 : 0); cycs.push_back(c);
                model_access(ack1 ? 1 : 0, 1'b0, a[ack1 ? 1 : 0], 64'd0, e, rd);
                checks++; if ({ack1 ? err1 : err0, get_rdata(ack1 ? 1 : 0)} !== {e, rd}) begin failures++;
                    $display("FAIL rr_data got=%h exp=%h", get_rdata(ack1 ? 1 : 0), rd); end
            end
            if (ports.size() == 4) req = 2'b00;
        end
        checks++; if (ports.size() !== 4) begin failures++; $display("FAIL rr_count got=%0d exp=4", ports.size()); end
        for (int i = 0; i < ports.size(); i++) begin
            checks++; if ({ports[i], cycs[i]} !== {i % 2, 2 * (i + 1)}) begin failures++;
                $display("FAIL rr_order[%0d] got port=%0d cyc=%0d exp port=%0d cyc=%0d", i, ports[i], cycs[i], i % 2, 2 * (i + 1)); end
        end
        req = 2'b00;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rr_idle got=%b exp=0", busy); end
    endtask

    task automatic test_random();
        obs_t o; logic e; logic [63:0] rd; logic [63:0] a, d; int p; logic w;
        for (int n = 0; n < 40; n++) begin
            p = int'($urandom_range(0, 1)); w = 1'($urandom_range(0, 1)); d = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       a = {$urandom, $urandom};
                1:       a = 64'($urandom_range(0, 70));
                default: a = 64'(8 * $urandom_range(0, 7));
            endcase
            run_single(p, w, a, d, o);
            model_access(p, w, a, d, e, rd);
            checks++; if ({o.lat, o.e, o.rd, o.oth, o.busy_c} !== {32'd2, e, rd, 32'd0, 32'd1}) begin failures++;
                $display("FAIL rand[%0d] p=%0d we=%b a=%h got lat=%0d err=%b rd=%h oth=%0d busy=%0d exp err=%b rd=%h",
                         n, p, w, a, o.lat, o.e, o.rd, o.oth, o.busy_c, e, rd); end
            checks++; if ({o.rd_c, o.wr_c} !== {((!w && !e) ? 32'd1 : 32'd0), ((w && !e) ? 32'd1 : 32'd0)}) begin failures++;
                $display("FAIL rand_strobes[%0d] got rd=%0d wr=%0d", n, o.rd_c, o.wr_c); end
            checks++; if (get_rdata(1 - p) !== model_rdata[1 - p]) begin failures++;
                $display("FAIL rand_other_rdata[%0d] got=%h exp=%h", n, get_rdata(1 - p), model_rdata[1 - p]); end
        end
        for (int i = 0; i < 8; i++) begin
            checks++; if (tb_mem[i] !== model_mem[i]) begin failures++;
                $display("FAIL rand_mem[%0d] got=%h exp=%h", i, tb_mem[i], model_mem[i]); end
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; mem_init = 1'b1; req = 2'b00; we = 2'b00;
        addr[0] = 64'd0; addr[1] = 64'd0; wdata[0] = 64'd0; wdata[1] = 64'd0;
        for (int i = 0; i < 8; i++) model_mem[i] = 64'(2 * i);
        model_rdata[0] = 64'd0; model_rdata[1] = 64'd0;
        repeat (3) @(posedge clk);
        #1; reset = 1'b0; mem_init = 1'b0;
        test_reset();
        test_read_basic();
        test_write_read();
        test_errors();
        test_regrant();
        test_reset_during_write();
        test_round_robin();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
